// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the matrix UART receive/transmit path.
package matrix_pkg;

   localparam int unsigned MAX_DIM = 5;
   localparam int unsigned DW      = 4;

   localparam logic [7:0] CH_0  = 8'h30;
   localparam logic [7:0] CH_SP = 8'h20;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSend,
      StWait,
      StDone
   } out_state_e;

endpackage

// File: rtl/matrix_digit_enc.sv
// Converts one matrix element to its decimal ASCII digits (one or two bytes).
module matrix_digit_enc
   import matrix_pkg::*;
(
   input  logic [DW-1:0] val,
   output logic [1:0]    ndig,
   output logic [7:0]    first_byte,
   output logic [7:0]    second_byte
);

   always_comb begin
      if (val > DW'(9)) begin
         ndig        = 2'd2;
         first_byte  = CH_0 + 8'd1;
         second_byte = CH_0 + 8'(val - DW'(10));
      end else begin
         ndig        = 2'd1;
         first_byte  = CH_0 + 8'(val);
         second_byte = CH_0;
      end
   end

endmodule

// File: rtl/matrix_output.sv
// Snapshots an up-to-5x5 matrix and streams it to uart_tx as ASCII text, one byte per handshake.
module matrix_output
   import matrix_pkg::*;
#(
   parameter logic [7:0] SEP_CHAR = CH_SP
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [3:0]                    mat_m,
   input  logic [3:0]                    mat_n,
   input  logic [MAX_DIM*MAX_DIM*DW-1:0] mat_data_flat,
   output logic [7:0]                    tx_data,
   output logic                          tx_start,
   input  logic                          tx_done,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int unsigned FlatW   = MAX_DIM * MAX_DIM * DW;
   localparam logic [3:0]  MaxDimW = 4'(MAX_DIM);

   out_state_e       state_q, state_d;
   logic [3:0]       m_q, m_d, n_q, n_d;
   logic [FlatW-1:0] data_q, data_d;
   logic [2:0]       row_q, row_d, col_q, col_d;
   logic [1:0]       chr_q, chr_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_start_q, tx_start_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic [DW-1:0] elem;
   logic [1:0]    ndig, sep_idx;
   logic [7:0]    dig0, dig1, cur_byte;
   logic          last_col, last_row, last_chr;

   assign elem = data_q[(32'(row_q) * MAX_DIM + 32'(col_q)) * DW +: DW];

   matrix_digit_enc u_digit_enc (
      .val        (elem),
      .ndig       (ndig),
      .first_byte (dig0),
      .second_byte(dig1)
   );

   // Char index walks the digits first, then the separator (or CR, LF on the last column).
   assign last_col = ({1'b0, col_q} == n_q - 4'd1);
   assign last_row = ({1'b0, row_q} == m_q - 4'd1);
   assign last_chr = (chr_q == ndig + {1'b0, last_col});
   assign sep_idx  = chr_q - ndig;

   always_comb begin
      if (chr_q < ndig) begin
         cur_byte = (chr_q == 2'd0) ? dig0 : dig1;
      end else if (last_col) begin
         cur_byte = (sep_idx == 2'd0) ? CH_CR : CH_LF;
      end else begin
         cur_byte = SEP_CHAR;
      end
   end

   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      n_d        = n_q;
      data_d     = data_q;
      row_d      = row_q;
      col_d      = col_q;
      chr_d      = chr_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               m_d    = mat_m;
               n_d    = mat_n;
               data_d = mat_data_flat;
               row_d  = 3'd0;
               col_d  = 3'd0;
               chr_d  = 2'd0;
               if (mat_m == 4'd0 || mat_m > MaxDimW || mat_n == 4'd0 || mat_n > MaxDimW) begin
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  err_d   = 1'b0;
                  busy_d  = 1'b1;
                  state_d = StLoad;
               end
            end
         end
         StLoad: begin
            tx_data_d  = cur_byte;
            tx_start_d = 1'b1;
            state_d    = StSend;
         end
         StSend: state_d = StWait;
         StWait: begin
            if (tx_done) begin
               state_d = StLoad;
               if (!last_chr) begin
                  chr_d = chr_q + 2'd1;
               end else begin
                  chr_d = 2'd0;
                  if (!last_col) begin
                     col_d = col_q + 3'd1;
                  end else begin
                     col_d = 3'd0;
                     if (!last_row) begin
                        row_d = row_q + 3'd1;
                     end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                     end
                  end
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         m_q        <= '0;
         n_q        <= '0;
         data_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         chr_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         n_q        <= n_d;
         data_q     <= data_d;
         row_q      <= row_d;
         col_q      <= col_d;
         chr_q      <= chr_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule
